// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - command, memory and write-back bus of the load/store unit
interface load_store_unit_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_load;
   logic [2:0]  cmd_dest;
   logic [15:0] cmd_base;
   logic [6:0]  cmd_imm;
   logic [15:0] cmd_sdata;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        wb_en;
   logic [2:0]  wb_dest;
   logic [15:0] wb_data;
   logic        done;
   logic        err;

   // The unit side: masters the memory bus, serves commands, drives write-back.
   modport master (
      input  cmd_valid, cmd_load, cmd_dest, cmd_base, cmd_imm, cmd_sdata,
      input  mem_rdata, mem_ack,
      output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
      output wb_en, wb_dest, wb_data, done, err
   );

   // The environment side: issues commands, answers memory requests.
   modport slave (
      output cmd_valid, cmd_load, cmd_dest, cmd_base, cmd_imm, cmd_sdata,
      output mem_rdata, mem_ack,
      input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
      input  wb_en, wb_dest, wb_data, done, err
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding LW/SW unit with memory timeout
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                clk,
   input logic                rst,
   load_store_unit_if.master  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WB = 2'd2} state_t;

   // Counter only needs to reach TIMEOUT_CYCLES-1; the final miss edge fires err.
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t         state;
   state_t         state_nxt;
   logic           op_load;
   logic [2:0]     dest_q;
   logic [15:0]    addr_q;
   logic [15:0]    sdata_q;
   logic [15:0]    rdata_q;
   logic [CW-1:0]  cnt;
   logic           err_q;
   logic           timeout_hit;

   // A zero timeout parameter leaves the unit waiting for ack indefinitely.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: ack wins over a coincident timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.cmd_valid) state_nxt = REQ;
         REQ: begin
            if (bus.mem_ack)       state_nxt = WB;
            else if (timeout_hit)  state_nxt = IDLE;
         end
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command latch, read-data capture, timeout counter and err pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_load <= 1'b0;
         dest_q  <= 3'd0;
         addr_q  <= 16'h0000;
         sdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         cnt     <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  op_load <= bus.cmd_load;
                  dest_q  <= bus.cmd_dest;
                  addr_q  <= bus.cmd_base + {{9{bus.cmd_imm[6]}}, bus.cmd_imm};
                  sdata_q <= bus.cmd_sdata;
                  cnt     <= '0;
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  if (op_load) rdata_q <= bus.mem_rdata;
               end else begin
                  cnt   <= cnt + 1'b1;
                  err_q <= timeout_hit;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state or taken straight from registers.
   always_comb begin
      bus.cmd_ready = (state == IDLE);
      bus.mem_req   = (state == REQ);
      bus.mem_we    = (state == REQ) && !op_load;
      bus.mem_addr  = addr_q;
      bus.mem_wdata = sdata_q;
      bus.done      = (state == WB);
      bus.wb_en     = (state == WB) && op_load && (dest_q != 3'd0);
      bus.wb_dest   = dest_q;
      bus.wb_data   = rdata_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized transaction-level check of load_store_unit
module tb_load_store_unit;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [15:0] m_addr = 16'h0000;
   logic [15:0] m_wdata = 16'h0000;

   load_store_unit_if bus();

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_cmd(input logic ld, input logic [2:0] dst, input logic [15:0] base,
                            input logic [6:0] imm, input logic [15:0] sd);
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = ld;
      bus.cmd_dest  = dst;
      bus.cmd_base  = base;
      bus.cmd_imm   = imm;
      bus.cmd_sdata = sd;
   endtask

   // ack_at: REQ cycle (1-based) on which ack is given; <1 means never.
   task automatic run_cmd(input logic ld, input logic [2:0] dst, input logic [15:0] base,
                          input logic [6:0] imm, input logic [15:0] sd, input int ack_at,
                          input logic [15:0] rd, input logic noise);
      int   off;
      int   exp_req;
      int   n_req = 0, n_done = 0, n_err = 0, n_wb = 0, n_wb_bad = 0, cyc = 0;
      logic timed_out;
      logic finished = 1'b0;
      off       = imm[6] ? int'(imm) - 128 : int'(imm);
      m_addr    = 16'((int'(base) + off + 65536) % 65536);
      m_wdata   = sd;
      timed_out = (ack_at < 1) || (ack_at > TO);
      exp_req   = timed_out ? TO : ack_at;

      @(negedge clk);
      check("start_ready", bus.cmd_ready, 1);
      check("start_err", bus.err, 0);
      drive_cmd(ld, dst, base, imm, sd);

      while (!finished && cyc < 20) begin
         @(negedge clk);
         cyc++;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 16'($urandom);
         if (noise) drive_cmd(1'($urandom), 3'($urandom), 16'($urandom), 7'($urandom), 16'($urandom));
         bus.cmd_valid = noise ? 1'($urandom) : 1'b0;
         if (bus.mem_req) begin
            n_req++;
            check("req_addr", bus.mem_addr, m_addr);
            check("req_we", bus.mem_we, !ld);
            check("req_wdata", bus.mem_wdata, m_wdata);
            if (n_req == ack_at) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = rd;
            end
         end
         if (bus.done) begin
            n_done++;
            if (noise) bus.mem_ack = 1'($urandom);
         end
         if (bus.wb_en) begin
            n_wb++;
            if (!bus.done) n_wb_bad++;
            check("wb_dest", bus.wb_dest, dst);
            check("wb_data", bus.wb_data, rd);
         end
         if (bus.err) n_err++;
         if (bus.cmd_ready) begin
            finished      = 1'b1;
            bus.cmd_valid = 1'b0;
            if (noise) bus.mem_ack = 1'($urandom);
         end
      end

      check("cmd_finished", finished, 1);
      check("n_req", n_req, exp_req);
      check("n_done", n_done, timed_out ? 0 : 1);
      check("n_err", n_err, timed_out ? 1 : 0);
      check("n_wb", n_wb, (!timed_out && ld && dst != 3'd0) ? 1 : 0);
      check("wb_outside", n_wb_bad, 0);
      check("idle_addr", bus.mem_addr, m_addr);
      check("idle_wdata", bus.mem_wdata, m_wdata);
      check("idle_we", bus.mem_we, 0);
   endtask

   task automatic reset_tests();
      int n_bad = 0;
      // reset in REQ, with a command also offered on the reset edge, then a stale ack
      @(negedge clk);
      bus.mem_ack = 1'b0;
      drive_cmd(1'b1, 3'd2, 16'h4321, 7'h05, 16'h7777);
      @(negedge clk);
      check("rst_pre_req", bus.mem_req, 1);
      drive_cmd(1'b1, 3'd6, 16'h1111, 7'h01, 16'h2222);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hA5A5;
      check("rst_req_drop", bus.mem_req, 0);
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_addr", bus.mem_addr, 16'h0000);
      check("rst_wdata", bus.mem_wdata, 16'h0000);
      m_addr  = 16'h0000;
      m_wdata = 16'h0000;
      repeat (3) begin
         @(negedge clk);
         if (bus.done || bus.wb_en || bus.err || bus.mem_req) n_bad++;
      end
      check("rst_quiet", n_bad, 0);
      bus.mem_ack = 1'b0;
      // reset in WB
      @(negedge clk);
      drive_cmd(1'b1, 3'd4, 16'h0100, 7'h02, 16'h0000);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'h3C3C;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check("rstwb_done_seen", bus.done, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstwb_done", bus.done, 0);
      check("rstwb_wb_en", bus.wb_en, 0);
      check("rstwb_wb_data", bus.wb_data, 16'h0000);
      check("rstwb_ready", bus.cmd_ready, 1);
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_load  = 1'b0;
      bus.cmd_dest  = 3'd0;
      bus.cmd_base  = 16'h0000;
      bus.cmd_imm   = 7'h00;
      bus.cmd_sdata = 16'h0000;
      bus.mem_rdata = 16'h0000;
      bus.mem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_wb_en", bus.wb_en, 0);
      check("rst_wb_dest", bus.wb_dest, 0);
      check("rst_wb_data", bus.wb_data, 16'h0000);
      check("rst_mem_addr", bus.mem_addr, 16'h0000);
      check("rst_mem_wdata", bus.mem_wdata, 16'h0000);
      rst = 1'b0;

      run_cmd(1'b1, 3'd3, 16'h0010, 7'h7F, 16'h0000, 2, 16'hBEEF, 1'b0);
      check("lw_neg_addr", bus.mem_addr, 16'h000F);
      run_cmd(1'b0, 3'd5, 16'hFFFF, 7'h01, 16'h1234, 1, 16'h9999, 1'b0);
      check("sw_wrap_addr", bus.mem_addr, 16'h0000);
      check("sw_wdata", bus.mem_wdata, 16'h1234);
      run_cmd(1'b1, 3'd0, 16'h2000, 7'h10, 16'h0000, 1, 16'h5555, 1'b0);
      run_cmd(1'b1, 3'd5, 16'h3000, 7'h40, 16'h0000, 0, 16'h0000, 1'b0);
      run_cmd(1'b1, 3'd5, 16'h3000, 7'h3F, 16'h0000, TO, 16'hC0DE, 1'b0);
      run_cmd(1'b0, 3'd1, 16'h8000, 7'h00, 16'hFACE, TO + 1, 16'h0000, 1'b1);
      reset_tests();
      run_cmd(1'b1, 3'd7, 16'h0042, 7'h00, 16'h0000, 3, 16'h0F0F, 1'b1);

      for (int i = 0; i < 60; i++) begin
         run_cmd(1'($urandom), 3'($urandom), 16'($urandom), 7'($urandom), 16'($urandom),
                 int'($urandom_range(0, TO + 2)), 16'($urandom), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles waiting for mem_ack; 0 SHALL disable the timeout.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  unit idle, command acceptable.
REQ-006 cmd_load  in  1  1 = LW, 0 = SW.
REQ-007 cmd_dest  in  3  LW destination register.
REQ-008 cmd_base  in  16  base register value (rB).
REQ-009 cmd_imm  in  7  signed 7-bit offset.
REQ-010 cmd_sdata  in  16  SW store data (rA value).
REQ-011 mem_req  out  1  memory request.
REQ-012 mem_we  out  1  1 = write.
REQ-013 mem_addr  out  16  word address.
REQ-014 mem_wdata  out  16  write data.
REQ-015 mem_rdata  in  16  read data, valid with mem_ack.
REQ-016 mem_ack  in  1  memory completion.
REQ-017 wb_en, wb_dest[2:0], wb_data[16]  out  register-file write port (feeds gpr write_en/write_dest/write_data).
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 err  out  1  one-cycle timeout pulse.

Function
REQ-020 States SHALL be IDLE, REQ, WB; cmd_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, cmd_valid=1 at a clock edge SHALL latch op, dest, sdata, and addr = cmd_base + sign_extend(cmd_imm), mod 2^16, then enter REQ.
REQ-022 cmd_valid outside IDLE SHALL be ignored; there is no queue.
REQ-023 In REQ, mem_req SHALL be 1 with mem_we = ~op, and mem_addr and mem_wdata held stable until completion.
REQ-024 mem_ack=1 at an edge in REQ SHALL capture mem_rdata (LW only) and enter WB; mem_req SHALL be 0 the following cycle.
REQ-025 Ack is allowed on the first REQ cycle (minimum latency: accept edge N, ack edge N+1, WB during cycle N+1..N+2).
REQ-026 mem_ack in IDLE or WB SHALL be ignored.
REQ-027 WB SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-028 In WB, wb_en SHALL be 1 only for LW with dest != 0, with wb_dest = dest and wb_data = captured rdata.
REQ-029 A SW, or a LW with dest = 0, SHALL produce wb_en = 0 but still pulse done.
REQ-030 A timeout counter SHALL clear on REQ entry and increment each REQ cycle without ack; on reaching TIMEOUT_CYCLES, the unit SHALL pulse err for one cycle, drop mem_req, return to IDLE, and produce no done and no wb_en.
REQ-031 Ack and timeout on the same edge SHALL resolve as ack.
REQ-032 wb_en SHALL never be 1 outside WB; at most one wb_en per command.
REQ-033 All outputs SHALL be driven from registers or state decode only; there SHALL be no combinational path from any input to any output.
REQ-034 When idle, mem_addr and mem_wdata SHALL hold their last values; mem_we SHALL be 0.

Reset
REQ-035 rst=1 SHALL force IDLE, and SHALL clear the counter, mem_req, mem_we, wb_en, done, and err to 0, and wb_dest, wb_data, mem_addr, and mem_wdata to 0x0000, at the next edge.
REQ-036 Reset mid-REQ or mid-WB SHALL abort the command with no wb_en, done, or err afterwards; a later mem_ack SHALL be ignored.
REQ-037 rst SHALL take priority over cmd_valid and mem_ack on the same edge.

Verification
REQ-038 LW dest=3, base=0x0010, imm=0x7F (-1), ack after 2 REQ cycles with rdata=0xBEEF -> mem_addr=0x000F, mem_we=0; one cycle of wb_en=1, wb_dest=3, wb_data=0xBEEF, done=1.
REQ-039 SW base=0xFFFF, imm=0x01, sdata=0x1234, ack on the first REQ cycle -> mem_addr=0x0000 (wrap), mem_we=1, mem_wdata=0x1234; done=1, wb_en=0.
REQ-040 LW dest=0, ack with rdata=0x5555 -> done=1, wb_en stays 0.
REQ-041 TIMEOUT_CYCLES=4, LW with ack never asserted -> mem_req high for 4 cycles, err pulses once, cmd_ready returns to 1, no wb_en; a second command is then accepted normally.
REQ-042 rst pulsed during REQ, then ack -> mem_req=0 after the reset edge, no wb_en or done; cmd_valid while busy -> ignored, mem_addr unchanged.
